if_fetch_unit: RTL and testbench

- Instruction-fetch front end that produces the {next address, instruction} pair consumed by the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a request/response handshake.
- Buffers returned words in a small FIFO.
- Honours ID-stage stalls and branch/jump redirects, discarding wrong-path fetches.

---
 rtl/if_fetch_unit.sv | 81 ++++++++
 tb/tb_if_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, issues single-outstanding imem fetches and buffers words for IF/ID
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_next_addr,
  output logic [31:0] out_instr
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   nxt_q [DEPTH];
  logic [31:0]   nxt_d [DEPTH];
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   ins_d [DEPTH];
  logic          fire, push, pop;
  assign imem_addr     = pc_q;
  assign out_valid     = count_q != '0;
  assign out_next_addr = out_valid ? nxt_q[rd_q] : '0;
  assign out_instr     = out_valid ? ins_q[rd_q] : '0;
  // Fetch FSM, PC update and FIFO bookkeeping; a redirect flushes and marks any in-flight response for dropping
  always_comb begin
    imem_req = state_q == REQ && count_q != FULL && !redirect && !rst;
    fire     = imem_req && imem_ready;
    push     = state_q == WAIT && imem_rvalid && !redirect;
    pop      = out_valid && !id_stall && !redirect;
    nxt_d    = nxt_q;
    ins_d    = ins_q;
    if (push) begin
      nxt_d[wr_q] = req_pc_q + 32'd4;
      ins_d[wr_q] = imem_rdata;
    end
    req_pc_d = fire ? pc_q : req_pc_q;
    pc_d     = redirect ? redirect_pc & ~32'h3 : fire ? pc_q + 32'd4 : pc_q;
    state_d  = redirect ? (state_q != REQ && !imem_rvalid ? DROP : REQ)
             : fire ? WAIT
             : state_q != REQ && imem_rvalid ? REQ : state_q;
    count_d  = redirect ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
    wr_d     = redirect ? '0 : wr_q + PW'(push);
    rd_d     = redirect ? '0 : rd_q + PW'(pop);
  end
  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      count_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end
  // FIFO storage needs no reset: entries are only visible through out_valid
  always_ff @(posedge clk) begin
    nxt_q <= nxt_d;
    ins_q <= ins_d;
  end
  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count_q == FULL && !pop));
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: memory model plus scoreboard of {next_addr, instr} checked at each pop
module tb_if_fetch_unit;
  logic        clk = 0, rst = 1, imem_ready = 0, imem_rvalid = 0, id_stall = 0, redirect = 0;
  logic [31:0] imem_rdata = 0, redirect_pc = 0;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, out_next_addr, out_instr;
  int          checks = 0, errors = 0;
  bit          auto_mode = 0;
  int          lat = 1, mem_cnt = 0;
  logic [31:0] mem_addr = 0;
  logic [63:0] e;
  logic [63:0] sb [$];
  logic [31:0] acc_q [$];

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_next_addr(out_next_addr), .out_instr(out_instr)
  );

  // Memory responder (instr = 0x2000_0000 + addr, lat cycles after accept) and pop-side scoreboard
  always @(negedge clk) begin
    if (auto_mode) begin
      if (rst) begin
        mem_cnt = 0; imem_rvalid = 0; sb.delete();
      end else begin
        if (redirect) sb.delete();
        if (out_valid && !id_stall && !redirect) begin
          checks++;
          if (sb.size() == 0) begin
            errors++; $display("FAIL sb_pop: unexpected output got %h/%h expected none", out_next_addr, out_instr);
          end else begin
            e = sb.pop_front();
            if ({out_next_addr, out_instr} !== e) begin
              errors++; $display("FAIL sb_pop: got %h/%h expected %h/%h", out_next_addr, out_instr, e[63:32], e[31:0]);
            end
          end
        end
        imem_rvalid = 0;
        if (mem_cnt == 1) begin imem_rvalid = 1; imem_rdata = 32'h2000_0000 + mem_addr; end
        if (mem_cnt != 0) mem_cnt--;
        if (imem_req && imem_ready) begin
          mem_cnt = lat; mem_addr = imem_addr; acc_q.push_back(imem_addr);
          sb.push_back({imem_addr + 32'd4, 32'h2000_0000 + imem_addr});
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1; redirect = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; acc_q.delete();
  endtask

  task automatic wait_accept(input string name);
    bit hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      hit = imem_req && imem_ready;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL %s_accept: got no accept expected one within 30 cycles", name); end
  endtask

  task automatic wait_out(input string name);
    bit hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      hit = out_valid;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL %s_valid: got no out_valid expected one within 30 cycles", name); end
  endtask

  task automatic test_reset();
    auto_mode = 0; imem_ready = 1; imem_rvalid = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if (out_next_addr !== 32'h0) begin errors++; $display("FAIL rst_next: got %h expected 0", out_next_addr); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", out_instr); end
  endtask

  task automatic test_stream();
    auto_mode = 1; lat = 1; id_stall = 0; imem_ready = 1;
    do_reset();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req: got %b/%h expected 1/00000000", imem_req, imem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_lat_c0: got %b expected 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_lat_c1: got %b expected 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_lat_c2: got %b expected 1", out_valid); end
    repeat (12) @(negedge clk);
    checks++;
    if (acc_q.size() < 3) begin errors++; $display("FAIL stream_addrs: got %0d fetches expected >=3", acc_q.size()); end
    else if (acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4 || acc_q[2] !== 32'h8) begin
      errors++; $display("FAIL stream_addrs: got %h %h %h expected 0 4 8", acc_q[0], acc_q[1], acc_q[2]);
    end
  endtask

  task automatic test_stall();
    id_stall = 1; lat = 1; imem_ready = 1;
    do_reset();
    repeat (10) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", out_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", imem_req); end
    checks++; if (out_next_addr !== 32'h4 || out_instr !== 32'h2000_0000) begin errors++; $display("FAIL stall_head: got %h/%h expected 00000004/20000000", out_next_addr, out_instr); end
    checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL stall_fill: got %0d fetches expected 2", acc_q.size()); end
    @(posedge clk); #1 id_stall = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_redirect_wait();
    lat = 3;
    wait_accept("rdw");
    @(posedge clk); #1 redirect = 1; redirect_pc = 32'h0000_0103; acc_q.delete();
    @(posedge clk); #1 redirect = 0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_drop_req: got %b expected 0", imem_req); end
    wait_out("rdw");
    checks++; if (acc_q.size() == 0 || acc_q[0] !== 32'h100) begin errors++; $display("FAIL rdw_addr: got %h expected 00000100", acc_q.size() ? acc_q[0] : 32'hx); end
    checks++; if (out_next_addr !== 32'h104 || out_instr !== 32'h2000_0100) begin errors++; $display("FAIL rdw_out: got %h/%h expected 00000104/20000100", out_next_addr, out_instr); end
    lat = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_redirect_same();
    lat = 1;
    wait_accept("rds");
    @(posedge clk); #1 redirect = 1; redirect_pc = 32'h200;
    @(posedge clk); #1 redirect = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rds_rvalid_empty: got %b expected 0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rds_rvalid_next: got %b/%h expected 1/00000200", imem_req, imem_addr); end
    @(posedge clk);
    @(posedge clk); #1 redirect = 1; redirect_pc = 32'h300;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rds_ready_gate: got %b expected 0", imem_req); end
    @(posedge clk); #1 redirect = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rds_ready_empty: got %b expected 0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL rds_ready_next: got %b/%h expected 1/00000300", imem_req, imem_addr); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_wrap();
    lat = 1;
    wait_accept("wrap");
    @(posedge clk);
    @(posedge clk); #1 redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1 redirect = 0; acc_q.delete();
    wait_out("wrap");
    checks++; if (out_next_addr !== 32'h0 || out_instr !== 32'h1FFF_FFFC) begin errors++; $display("FAIL wrap_out: got %h/%h expected 00000000/1ffffffc", out_next_addr, out_instr); end
    repeat (4) @(negedge clk);
    checks++;
    if (acc_q.size() < 2 || acc_q[0] !== 32'hFFFF_FFFC || acc_q[1] !== 32'h0) begin
      errors++; $display("FAIL wrap_addr: got %0d fetches, second %h expected fffffffc then 00000000", acc_q.size(), acc_q.size() > 1 ? acc_q[1] : 32'hx);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      id_stall = $urandom_range(0, 3) == 0;
      imem_ready = 1'($urandom_range(0, 1));
      lat = $urandom_range(1, 3);
      redirect = $urandom_range(0, 15) == 0;
      redirect_pc = $urandom;
    end
    @(posedge clk); #1 id_stall = 0; redirect = 0; imem_ready = 0;
    repeat (10) @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending expected 0", sb.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_wait();
    auto_mode = 0; imem_rvalid = 0; imem_ready = 1; id_stall = 0;
    do_reset();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rw_req: got %b/%h expected 1/00000000", imem_req, imem_addr); end
    @(posedge clk); #1 imem_ready = 0; rst = 1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_rst_req: got %b expected 0", imem_req); end
    @(posedge clk); #1 rst = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rw_refetch: got %b/%h expected 1/00000000", imem_req, imem_addr); end
    @(posedge clk); #1 imem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin errors++; $display("FAIL rw_stray: got %b/%h expected 0/00000000", out_valid, out_instr); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_same();
    test_wrap();
    test_random();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
